// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_if
// Description : Fetch, register-file, write-back, hazard and execute-side
//               signals of the RV32I decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_stage_if;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_load_valid;
    logic [4:0]  ex_load_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_rs1_val;
    logic [31:0] out_rs2_val;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [31:0] out_imm;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic        out_rd_we;
    logic        out_is_load;
    logic        out_illegal;

    modport slave (
        input  flush, in_valid, in_instr, in_pc, rf_rdata1, rf_rdata2,
               wb_we, wb_addr, wb_data, ex_load_valid, ex_load_rd, out_ready,
        output in_ready, rf_raddr1, rf_raddr2, out_valid, out_pc,
               out_rs1_val, out_rs2_val, out_rs1, out_rs2, out_rd, out_imm,
               out_opcode, out_funct3, out_funct7, out_rd_we, out_is_load,
               out_illegal
    );

    modport master (
        output flush, in_valid, in_instr, in_pc, rf_rdata1, rf_rdata2,
               wb_we, wb_addr, wb_data, ex_load_valid, ex_load_rd, out_ready,
        input  in_ready, rf_raddr1, rf_raddr2, out_valid, out_pc,
               out_rs1_val, out_rs2_val, out_rs1, out_rs2, out_rd, out_imm,
               out_opcode, out_funct3, out_funct7, out_rd_we, out_is_load,
               out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : RV32I decode with write-back bypass, immediate generation,
//               load-use hazard stall and a decode-to-execute register.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage (
    input  wire logic     clk,
    input  wire logic     reset,
    decode_stage_if.slave bus
);
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_opimm  = 7'b0010011;
    localparam logic [6:0] c_op_op     = 7'b0110011;
    localparam logic [6:0] c_op_fence  = 7'b0001111;
    localparam logic [6:0] c_op_system = 7'b1110011;

    logic [31:0] w_instr;
    logic [6:0]  w_opcode;
    logic [4:0]  w_rs1_field, w_rs2_field, w_rd_field;
    logic        w_is_lui, w_is_auipc, w_is_jal, w_is_jalr, w_is_branch;
    logic        w_is_load, w_is_store, w_is_opimm, w_is_op, w_is_fence;
    logic        w_is_system, w_legal;
    logic        w_uses_rs1, w_uses_rs2, w_writes_rd;
    logic [4:0]  w_rs1, w_rs2, w_rd;
    logic [31:0] w_imm, w_rs1_val, w_rs2_val;
    logic        w_hazard, w_in_ready, w_accept;

    logic        r_valid;
    logic [31:0] r_pc, r_rs1_val, r_rs2_val, r_imm, r_instr;
    logic [4:0]  r_rs1, r_rs2, r_rd;
    logic        r_rd_we, r_is_load, r_illegal;

    assign w_instr     = bus.in_instr;
    assign w_opcode    = w_instr[6:0];
    assign w_rs1_field = w_instr[19:15];
    assign w_rs2_field = w_instr[24:20];
    assign w_rd_field  = w_instr[11:7];

    assign w_is_lui    = (w_opcode == c_op_lui);
    assign w_is_auipc  = (w_opcode == c_op_auipc);
    assign w_is_jal    = (w_opcode == c_op_jal);
    assign w_is_jalr   = (w_opcode == c_op_jalr);
    assign w_is_branch = (w_opcode == c_op_branch);
    assign w_is_load   = (w_opcode == c_op_load);
    assign w_is_store  = (w_opcode == c_op_store);
    assign w_is_opimm  = (w_opcode == c_op_opimm);
    assign w_is_op     = (w_opcode == c_op_op);
    assign w_is_fence  = (w_opcode == c_op_fence);
    assign w_is_system = (w_opcode == c_op_system);
    assign w_legal     = w_is_lui | w_is_auipc | w_is_jal | w_is_jalr | w_is_branch
                       | w_is_load | w_is_store | w_is_opimm | w_is_op
                       | w_is_fence | w_is_system;

    assign w_uses_rs1  = !(w_is_lui | w_is_auipc | w_is_jal);
    assign w_uses_rs2  = w_is_op | w_is_store | w_is_branch;
    assign w_writes_rd = !(w_is_store | w_is_branch);

    assign w_rs1 = w_uses_rs1  ? w_rs1_field : 5'd0;
    assign w_rs2 = w_uses_rs2  ? w_rs2_field : 5'd0;
    assign w_rd  = w_writes_rd ? w_rd_field  : 5'd0;

    assign bus.rf_raddr1 = w_rs1_field;
    assign bus.rf_raddr2 = w_rs2_field;

    always_comb begin
        w_imm = 32'd0;
        if (w_is_opimm | w_is_load | w_is_jalr | w_is_system)
            w_imm = {{20{w_instr[31]}}, w_instr[31:20]};
        else if (w_is_store)
            w_imm = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
        else if (w_is_branch)
            w_imm = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                     w_instr[30:25], w_instr[11:8], 1'b0};
        else if (w_is_lui | w_is_auipc)
            w_imm = {w_instr[31:12], 12'd0};
        else if (w_is_jal)
            w_imm = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                     w_instr[20], w_instr[30:21], 1'b0};
    end

    // The register file only commits on the edge, so a same-cycle write must be forwarded
    always_comb begin
        w_rs1_val = bus.rf_rdata1;
        if (w_rs1 == 5'd0)
            w_rs1_val = 32'd0;
        else if (bus.wb_we && (bus.wb_addr == w_rs1))
            w_rs1_val = bus.wb_data;
        w_rs2_val = bus.rf_rdata2;
        if (w_rs2 == 5'd0)
            w_rs2_val = 32'd0;
        else if (bus.wb_we && (bus.wb_addr == w_rs2))
            w_rs2_val = bus.wb_data;
    end

    assign w_hazard = bus.in_valid && bus.ex_load_valid && (bus.ex_load_rd != 5'd0)
                   && ((w_uses_rs1 && (w_rs1_field == bus.ex_load_rd))
                    || (w_uses_rs2 && (w_rs2_field == bus.ex_load_rd)));

    assign w_in_ready  = bus.flush || (!w_hazard && (!r_valid || bus.out_ready));
    assign w_accept    = bus.in_valid && w_in_ready && !bus.flush;
    assign bus.in_ready = w_in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_pc      <= 32'd0;
            r_rs1_val <= 32'd0;
            r_rs2_val <= 32'd0;
            r_imm     <= 32'd0;
            r_instr   <= 32'd0;
            r_rs1     <= 5'd0;
            r_rs2     <= 5'd0;
            r_rd      <= 5'd0;
            r_rd_we   <= 1'b0;
            r_is_load <= 1'b0;
            r_illegal <= 1'b0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_pc      <= bus.in_pc;
            r_rs1_val <= w_rs1_val;
            r_rs2_val <= w_rs2_val;
            r_imm     <= w_imm;
            r_instr   <= w_instr;
            r_rs1     <= w_rs1;
            r_rs2     <= w_rs2;
            r_rd      <= w_rd;
            r_rd_we   <= w_writes_rd && (w_rd_field != 5'd0);
            r_is_load <= w_is_load;
            r_illegal <= !w_legal;
        end else if (r_valid && bus.out_ready) begin
            r_valid <= 1'b0;
        end else if (r_valid) begin
            // Stalled operands would otherwise miss a write-back that lands while held
            if (bus.wb_we && (bus.wb_addr != 5'd0) && (bus.wb_addr == r_rs1))
                r_rs1_val <= bus.wb_data;
            if (bus.wb_we && (bus.wb_addr != 5'd0) && (bus.wb_addr == r_rs2))
                r_rs2_val <= bus.wb_data;
        end
    end

    assign bus.out_valid   = r_valid;
    assign bus.out_pc      = r_pc;
    assign bus.out_rs1_val = r_rs1_val;
    assign bus.out_rs2_val = r_rs2_val;
    assign bus.out_rs1     = r_rs1;
    assign bus.out_rs2     = r_rs2;
    assign bus.out_rd      = r_rd;
    assign bus.out_imm     = r_imm;
    assign bus.out_opcode  = r_instr[6:0];
    assign bus.out_funct3  = r_instr[14:12];
    assign bus.out_funct7  = r_instr[31:25];
    assign bus.out_rd_we   = r_rd_we;
    assign bus.out_is_load = r_is_load;
    assign bus.out_illegal = r_illegal;

    logic w_unused;
    assign w_unused = ^r_instr[11:7] ^ ^r_instr[24:15];
endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Directed scoreboard bench for the RV32I decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic        rd_we;
        logic        is_load;
        logic        illegal;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    decode_stage_if bus ();
    decode_stage dut (.clk(clk), .reset(reset), .bus(bus));

    logic [31:0] regs [32];
    exp_t        sb [$];
    int          n_cmp = 0;
    int          n_fail = 0;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= (i == 7) ? 32'd0 : 32'h1000 + 32'(i * 16);
        end else if (bus.wb_we && bus.wb_addr != 5'd0) begin
            regs[bus.wb_addr] <= bus.wb_data;
        end
    end
    assign bus.rf_rdata1 = regs[bus.rf_raddr1];
    assign bus.rf_rdata2 = regs[bus.rf_raddr2];

    function automatic logic [31:0] rv(input logic [4:0] r);
        return (r == 5'd0) ? 32'd0 : regs[r];
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
            input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
            input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
            input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
            input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] instr,
            input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
            input logic [31:0] imm, input logic [31:0] v1, input logic [31:0] v2,
            input logic rd_we, input logic is_load, input logic illegal);
        exp_t e;
        e.pc = pc; e.rs1_val = v1; e.rs2_val = v2;
        e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.imm = imm;
        e.opcode = instr[6:0]; e.funct3 = instr[14:12]; e.funct7 = instr[31:25];
        e.rd_we = rd_we; e.is_load = is_load; e.illegal = illegal;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Negedge sample point: retire any output the execute side consumes this cycle
    task automatic half();
        exp_t e, o;
        @(negedge clk);
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $error("FAIL sb_unexpected: observed out_pc=%h expected no output", bus.out_pc);
            end else begin
                e = sb.pop_front();
                o.pc = bus.out_pc; o.rs1_val = bus.out_rs1_val; o.rs2_val = bus.out_rs2_val;
                o.rs1 = bus.out_rs1; o.rs2 = bus.out_rs2; o.rd = bus.out_rd;
                o.imm = bus.out_imm; o.opcode = bus.out_opcode; o.funct3 = bus.out_funct3;
                o.funct7 = bus.out_funct7; o.rd_we = bus.out_rd_we;
                o.is_load = bus.out_is_load; o.illegal = bus.out_illegal;
                assert (o === e) else begin
                    n_fail++;
                    $error("FAIL sb_out pc=%h: observed=%h expected=%h", e.pc, o, e);
                end
            end
        end
    endtask

    task automatic fin();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        bus.in_valid = v;
        bus.in_instr = instr;
        bus.in_pc    = pc;
    endtask

    logic [31:0] ins;
    logic [31:0] seq_i [8];
    exp_t        seq_e [8];

    initial begin
        reset = 1'b1;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_instr = 32'd0; bus.in_pc = 32'd0;
        bus.wb_we = 1'b0; bus.wb_addr = 5'd0; bus.wb_data = 32'd0;
        bus.ex_load_valid = 1'b0; bus.ex_load_rd = 5'd0; bus.out_ready = 1'b0;

        // Reset state
        half();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_pc", bus.out_pc, 0);
        chk("rst_out_imm", bus.out_imm, 0);
        chk("rst_out_rs1_val", bus.out_rs1_val, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        fin();
        reset = 1'b0;
        fin();

        // ADDI x5,x0,-3
        bus.out_ready = 1'b1;
        drive(1'b1, 32'hFFD00293, 32'h100);
        sb.push_back(mk(32'h100, 32'hFFD00293, 0, 0, 5, 32'hFFFFFFFD, 0, 0, 1, 0, 0));
        half();
        chk("addi_in_ready", bus.in_ready, 1);
        fin();

        // ADD x1,x7,x7 with same-cycle write-back of x7 (also drains ADDI)
        ins = enc_r(7'd0, 5'd7, 5'd7, 3'd0, 5'd1);
        drive(1'b1, ins, 32'h104);
        bus.wb_we = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'h1234;
        sb.push_back(mk(32'h104, ins, 7, 7, 1, 0, 32'h1234, 32'h1234, 1, 0, 0));
        half();
        chk("b2b_in_ready", bus.in_ready, 1);
        fin();
        bus.wb_we = 1'b0;

        // SW x3,0(x2) against a load to x3 in execute
        ins = enc_s(12'd0, 5'd3, 5'd2, 3'b010);
        drive(1'b1, ins, 32'h108);
        bus.ex_load_valid = 1'b1; bus.ex_load_rd = 5'd3;
        half();
        chk("hazard_in_ready", bus.in_ready, 0);
        fin();
        bus.ex_load_valid = 1'b0;
        sb.push_back(mk(32'h108, ins, 2, 3, 0, 0, rv(2), rv(3), 0, 0, 0));
        half();
        chk("hazard_no_bubble", bus.out_valid, 0);
        chk("hazard_release_ready", bus.in_ready, 1);
        fin();
        drive(1'b0, 32'd0, 32'd0);
        half();
        fin();

        // ADD x1,x2,x4 held while x4 is written back
        ins = enc_r(7'd0, 5'd4, 5'd2, 3'd0, 5'd1);
        bus.out_ready = 1'b0;
        drive(1'b1, ins, 32'h10C);
        sb.push_back(mk(32'h10C, ins, 2, 4, 1, 0, rv(2), 32'h0000BEEF, 1, 0, 0));
        half();
        fin();
        drive(1'b0, 32'd0, 32'd0);
        bus.wb_we = 1'b1; bus.wb_addr = 5'd4; bus.wb_data = 32'h0000BEEF;
        half();
        chk("hold_in_ready", bus.in_ready, 0);
        fin();
        bus.wb_we = 1'b0;
        half();
        chk("hold_out_valid", bus.out_valid, 1);
        chk("hold_rs2_refresh", bus.out_rs2_val, 32'h0000BEEF);
        fin();
        bus.out_ready = 1'b1;
        half();
        fin();

        // Flush with an instruction offered and one held
        bus.out_ready = 1'b0;
        drive(1'b1, enc_i(12'd5, 5'd0, 3'd0, 5'd6, 7'b0010011), 32'h200);
        half();
        fin();
        bus.flush = 1'b1;
        drive(1'b1, 32'hABCDE537, 32'h204);
        half();
        chk("flush_in_ready", bus.in_ready, 1);
        chk("flush_pre_valid", bus.out_valid, 1);
        fin();
        bus.flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        bus.out_ready = 1'b1;
        half();
        chk("flush_out_valid", bus.out_valid, 0);
        fin();

        // Back-to-back immediate formats plus load, x0 destination and illegal
        seq_i[0] = enc_b(-13'sd8, 5'd2, 5'd1, 3'd0);
        seq_e[0] = mk(32'h300, seq_i[0], 1, 2, 0, 32'hFFFFFFF8, rv(1), rv(2), 0, 0, 0);
        seq_i[1] = enc_j(21'd2048, 5'd1);
        seq_e[1] = mk(32'h304, seq_i[1], 0, 0, 1, 32'h00000800, 0, 0, 1, 0, 0);
        seq_i[2] = {20'hABCDE, 5'd10, 7'b0110111};
        seq_e[2] = mk(32'h308, seq_i[2], 0, 0, 10, 32'hABCDE000, 0, 0, 1, 0, 0);
        seq_i[3] = enc_s(12'hFFC, 5'd5, 5'd6, 3'b010);
        seq_e[3] = mk(32'h30C, seq_i[3], 6, 5, 0, 32'hFFFFFFFC, rv(6), rv(5), 0, 0, 0);
        seq_i[4] = enc_i(12'd4, 5'd9, 3'b010, 5'd8, 7'b0000011);
        seq_e[4] = mk(32'h310, seq_i[4], 9, 0, 8, 32'h4, rv(9), 0, 1, 1, 0);
        seq_i[5] = enc_i(12'd1, 5'd0, 3'd0, 5'd0, 7'b0010011);
        seq_e[5] = mk(32'h314, seq_i[5], 0, 0, 0, 32'h1, 0, 0, 0, 0, 0);
        seq_i[6] = enc_i(12'h123, 5'd9, 3'd0, 5'd11, 7'b1111111);
        seq_e[6] = mk(32'h318, seq_i[6], 9, 0, 11, 32'h0, rv(9), 0, 1, 0, 1);
        seq_i[7] = enc_r(7'b0100000, 5'd12, 5'd13, 3'd0, 5'd14);
        seq_e[7] = mk(32'h31C, seq_i[7], 13, 12, 14, 32'h0, rv(13), rv(12), 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, seq_i[i], seq_e[i].pc);
            sb.push_back(seq_e[i]);
            half();
            if (i > 0) chk("stream_out_valid", bus.out_valid, 1);
            chk("stream_in_ready", bus.in_ready, 1);
            fin();
        end
        drive(1'b0, 32'd0, 32'd0);
        half();
        fin();

        // Asynchronous reset while an instruction is held
        bus.out_ready = 1'b0;
        drive(1'b1, 32'hFFD00293, 32'h400);
        half();
        fin();
        drive(1'b0, 32'd0, 32'd0);
        chk("pre_areset_valid", bus.out_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("areset_out_valid", bus.out_valid, 0);
        chk("areset_out_pc", bus.out_pc, 0);
        chk("areset_out_imm", bus.out_imm, 0);
        half();
        fin();
        reset = 1'b0;
        fin();

        chk("sb_drained", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
